// File: rtl/cpu_mem_loader_if.sv
// Bundle of every signal between the loader and its neighbours: host control,
// program input stream, dump output stream, and both CPU external memory ports.
// master = loader side, slave = host / CPU-wrapper side.
interface cpu_mem_loader_if #(
  parameter int RUN_W = 32
) ();
  // host control and status
  logic             start;
  logic [9:0]       prog_len;
  logic [RUN_W-1:0] run_cycles;
  logic [10:0]      dump_len;
  logic             busy;
  logic             done;
  logic             error;
  logic             cpu_enable;
  // program input stream
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  // dump output stream
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  // instruction memory external port
  logic [63:0]      addr_ext;
  logic             wen_ext;
  logic             ren_ext;
  logic [31:0]      wdata_ext;
  logic [31:0]      rdata_ext;
  // data memory external port
  logic [63:0]      addr_ext_2;
  logic             wen_ext_2;
  logic             ren_ext_2;
  logic [63:0]      wdata_ext_2;
  logic [63:0]      rdata_ext_2;

  modport master (
    input  start, prog_len, run_cycles, dump_len,
    input  in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    output busy, done, error, cpu_enable,
    output in_ready, out_valid, out_data,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output start, prog_len, run_cycles, dump_len,
    output in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    input  busy, done, error, cpu_enable,
    input  in_ready, out_valid, out_data,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/cpu_mem_loader.sv
// Host-side initiator for the CPU external memory ports: loads a program into
// IMEM from an input stream, runs the CPU for a fixed cycle count, then reads
// DMEM back and emits each word on an output stream.
// Latency: one program word per cycle while in_valid; one dump word per >=3 cycles.
// Backpressure: in_ready is high only in LOAD; out_valid/out_data hold until out_ready.
// Ports: clk, arst_n (synchronous active-low), bus (cpu_mem_loader_if.master).
// Optional feature macro LOADER_VERIFY_EN: read back IMEM after LOAD and flag
// any mismatch on a sticky error output; without it error and ren_ext are 0.
module cpu_mem_loader #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128,
  parameter int RUN_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  cpu_mem_loader_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_VRD,    // verify: issue IMEM read
    S_VCHK,   // verify: compare returned word
    S_RUN,
    S_DRD,
    S_DWAIT,
    S_DOUT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [10:0]      idx_q, idx_d;
  logic [10:0]      plen_q, plen_d;
  logic [10:0]      dlen_q, dlen_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] rcnt_q, rcnt_d;
  logic [63:0]      odat_q, odat_d;

`ifdef LOADER_VERIFY_EN
  localparam int IAW = $clog2(IMEM_WORDS);
  logic             err_q, err_d;
  // Copy of every loaded word, needed to know what readback should return.
  logic [31:0]      shadow_q [IMEM_WORDS];
`else
  // Readback data has no consumer when verification is compiled out.
  logic             unused_rdata;
  assign unused_rdata = ^bus.rdata_ext;
`endif

  // Lengths beyond the memory depth are cut so the address never wraps.
  function automatic logic [10:0] clamp_len(input logic [10:0] len, input int depth);
    if (int'(len) > depth) return 11'(depth);
    return len;
  endfunction

  // First non-empty phase once loading (and verify) is behind us.
  function automatic state_e after_load(input logic [RUN_W-1:0] rc, input logic [10:0] dl);
    if (rc != '0) return S_RUN;
    if (dl != '0) return S_DRD;
    return S_DONE;
  endfunction

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      plen_q  <= '0;
      dlen_q  <= '0;
      run_q   <= '0;
      rcnt_q  <= '0;
      odat_q  <= '0;
`ifdef LOADER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      plen_q  <= plen_d;
      dlen_q  <= dlen_d;
      run_q   <= run_d;
      rcnt_q  <= rcnt_d;
      odat_q  <= odat_d;
`ifdef LOADER_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

`ifdef LOADER_VERIFY_EN
  // Shadow store is pure data, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && bus.in_valid) begin
      shadow_q[idx_q[IAW-1:0]] <= bus.in_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    plen_d  = plen_q;
    dlen_d  = dlen_q;
    run_d   = run_q;
    rcnt_d  = rcnt_q;
    odat_d  = odat_q;
`ifdef LOADER_VERIFY_EN
    err_d   = err_q;
`endif
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.cpu_enable = 1'b0;
    bus.done       = 1'b0;
    bus.addr_ext   = '0;
    bus.wen_ext    = 1'b0;
    bus.ren_ext    = 1'b0;
    bus.wdata_ext  = '0;
    bus.addr_ext_2 = '0;
    bus.ren_ext_2  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          plen_d = clamp_len({1'b0, bus.prog_len}, IMEM_WORDS);
          dlen_d = clamp_len(bus.dump_len, DMEM_WORDS);
          run_d  = bus.run_cycles;
          idx_d  = '0;
          rcnt_d = '0;
`ifdef LOADER_VERIFY_EN
          err_d  = 1'b0;
`endif
          // Decide on the freshly clamped values so empty phases are skipped now.
          state_d = (plen_d != '0) ? S_LOAD : after_load(run_d, dlen_d);
        end
      end

      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.wen_ext   = 1'b1;
          bus.wdata_ext = bus.in_data;
          bus.addr_ext  = 64'({idx_q, 2'b00});
          if (idx_q == plen_q - 11'd1) begin
            idx_d = '0;
`ifdef LOADER_VERIFY_EN
            state_d = S_VRD;
`else
            state_d = after_load(run_q, dlen_q);
`endif
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end

`ifdef LOADER_VERIFY_EN
      S_VRD: begin
        bus.ren_ext  = 1'b1;
        bus.addr_ext = 64'({idx_q, 2'b00});
        state_d      = S_VCHK;
      end

      S_VCHK: begin
        // rdata_ext now carries the word requested in S_VRD.
        if (bus.rdata_ext != shadow_q[idx_q[IAW-1:0]]) begin
          err_d = 1'b1;
        end
        if (idx_q == plen_q - 11'd1) begin
          idx_d   = '0;
          state_d = after_load(run_q, dlen_q);
        end else begin
          idx_d   = idx_q + 11'd1;
          state_d = S_VRD;
        end
      end
`endif

      S_RUN: begin
        bus.cpu_enable = 1'b1;
        if (rcnt_q == run_q - RUN_W'(1)) begin
          rcnt_d  = '0;
          state_d = (dlen_q != '0) ? S_DRD : S_DONE;
        end else begin
          rcnt_d = rcnt_q + RUN_W'(1);
        end
      end

      S_DRD: begin
        bus.ren_ext_2  = 1'b1;
        bus.addr_ext_2 = 64'({idx_q, 3'b000});
        state_d        = S_DWAIT;
      end

      S_DWAIT: begin
        odat_d  = bus.rdata_ext_2;
        state_d = S_DOUT;
      end

      S_DOUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (idx_q == dlen_q - 11'd1) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 11'd1;
            state_d = S_DRD;
          end
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.out_data    = odat_q;
  assign bus.wen_ext_2   = 1'b0;
  assign bus.wdata_ext_2 = '0;
`ifdef LOADER_VERIFY_EN
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_loader.sv
module tb_cpu_mem_loader;
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  cpu_mem_loader_if #(.RUN_W(32)) bus ();

  cpu_mem_loader #(
    .IMEM_WORDS(128),
    .DMEM_WORDS(128),
    .RUN_W     (32)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // memory models (1-cycle read latency)
  logic [31:0] imem [128];
  logic [63:0] dmem [128];
  bit          corrupt = 1'b0;

  always @(posedge clk) begin
    if (bus.wen_ext) imem[bus.addr_ext[8:2]] <= bus.wdata_ext;
    bus.rdata_ext   <= imem[bus.addr_ext[8:2]] ^
                       ((corrupt && bus.addr_ext[8:2] == 7'd1) ? 32'h1 : 32'h0);
    bus.rdata_ext_2 <= dmem[bus.addr_ext_2[9:3]];
  end

  // monitor, sampled mid-cycle
  logic [63:0] wr_addr[$], wr_dat[$], rd2_addr[$], outq[$];
  int  cyc, n_inrdy, n_en, en_first, en_last, n_done, n_unstable, n_both, n_ren1, n_dmemw;
  bit  stall_prev;
  logic [63:0] stall_dat;

  always @(negedge clk) begin
    cyc++;
    if (bus.wen_ext) begin
      wr_addr.push_back(bus.addr_ext);
      wr_dat.push_back(64'(bus.wdata_ext));
    end
    if (bus.in_ready) n_inrdy++;
    if (bus.cpu_enable) begin
      if (n_en == 0) en_first = cyc;
      en_last = cyc;
      n_en++;
    end
    if (bus.ren_ext_2) rd2_addr.push_back(bus.addr_ext_2);
    if (bus.ren_ext) n_ren1++;
    if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
    if (stall_prev && bus.out_data != stall_dat) n_unstable++;
    stall_prev = bus.out_valid && !bus.out_ready;
    stall_dat  = bus.out_data;
    if (bus.done) n_done++;
    if (bus.wen_ext && bus.ren_ext) n_both++;
    if (bus.wen_ext_2 || bus.wdata_ext_2 != 64'd0) n_dmemw++;
  end

  task automatic clear_mon();
    wr_addr.delete(); wr_dat.delete(); rd2_addr.delete(); outq.delete();
    n_inrdy = 0; n_en = 0; en_first = 0; en_last = 0; n_done = 0;
    n_unstable = 0; n_both = 0; n_ren1 = 0; n_dmemw = 0; stall_prev = 1'b0;
  endtask

  function automatic logic [31:0] pword(input int i);
    case (i)
      0:       return 32'h00500093;
      1:       return 32'h00A00113;
      2:       return 32'h002081B3;
      default: return 32'hC0DE0000 | 32'(i);
    endcase
  endfunction

  function automatic logic [63:0] dword(input int i);
    if (i < 4) return 64'h11 * 64'(i + 1);
    return 64'hDEAD_0000_0000_0000 | 64'(i);
  endfunction

  // Launch a sequence and run until done (or budget expires).
  task automatic run_seq(input logic [9:0] pl, input logic [31:0] rc, input logic [10:0] dl,
                         input bit tog, input bit ghost, input int budget);
    int wptr;
    bit xfer;
    bit seen;
    wptr = 0;
    seen = 1'b0;
    clear_mon();
    bus.prog_len   = pl;
    bus.run_cycles = rc;
    bus.dump_len   = dl;
    bus.in_valid   = 1'b1;
    bus.in_data    = pword(0);
    bus.out_ready  = 1'b1;
    bus.start      = 1'b1;
    for (int i = 0; i < budget && !seen; i++) begin
      xfer = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (xfer) begin
        wptr++;
        bus.in_data = pword(wptr);
      end
      bus.start = ghost && (i == 8);   // a start mid-sequence must be ignored
      if (tog) bus.out_ready = ~bus.out_ready;
      if (n_done != 0) seen = 1'b1;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("seq_done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    chk("idle_after_done_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      dmem[i] = dword(i);
      imem[i] = 32'd0;
    end
    arst_n = 1'b0;
    bus.start = 1'b0; bus.prog_len = '0; bus.run_cycles = '0; bus.dump_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      64'(bus.busy),       64'd0);
    chk("rst_done",      64'(bus.done),       64'd0);
    chk("rst_cpu_en",    64'(bus.cpu_enable), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),   64'd0);
    chk("rst_out_valid", 64'(bus.out_valid),  64'd0);
    chk("rst_out_data",  bus.out_data,        64'd0);
    chk("rst_wen_ren",   64'({bus.wen_ext, bus.ren_ext, bus.ren_ext_2}), 64'd0);
    chk("rst_error",     64'(bus.error),      64'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // tests 1-3 in one sequence: load 3 words, run 20, dump 4 with stalls
    run_seq(10'd3, 32'd20, 11'd4, 1'b1, 1'b1, 600);
    chk("t1_nwrites", 64'(wr_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_addr%0d", i), wr_addr[i], 64'(4 * i));
      chk($sformatf("t1_data%0d", i), wr_dat[i], 64'(pword(i)));
      chk($sformatf("t1_imem%0d", i), 64'(imem[i]), 64'(pword(i)));
    end
    chk("t1_in_ready_cycles", 64'(n_inrdy), 64'd3);
    chk("t2_en_cycles", 64'(n_en), 64'd20);
    chk("t2_en_contig", 64'(en_last - en_first), 64'd19);
    chk("t3_nreads", 64'(rd2_addr.size()), 64'd4);
    chk("t3_nout", 64'(outq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_raddr%0d", i), rd2_addr[i], 64'(8 * i));
      chk($sformatf("t3_out%0d", i), outq[i], dword(i));
    end
    chk("t3_stable", 64'(n_unstable), 64'd0);
    chk("t3_done_once", 64'(n_done), 64'd1);
    chk("t3_wen_ren_excl", 64'(n_both), 64'd0);
    chk("t3_no_dmem_write", 64'(n_dmemw), 64'd0);
    chk("t1_error_clean", 64'(bus.error), 64'd0);
`ifndef LOADER_VERIFY_EN
    chk("t1_no_imem_read", 64'(n_ren1), 64'd0);
`endif

    // test 4: everything empty -> done on next cycle, no memory access
    clear_mon();
    bus.prog_len = '0; bus.run_cycles = '0; bus.dump_len = '0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t4_done_pulse", 64'(bus.done), 64'd1);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("t4_done_gone", 64'(bus.done), 64'd0);
    chk("t4_no_access", 64'(wr_addr.size() + rd2_addr.size() + n_en + n_ren1), 64'd0);

    // test 5: reset during RUN at cycle 5
    clear_mon();
    bus.prog_len = '0; bus.run_cycles = 32'd100; bus.dump_len = 11'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    arst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_cpu_en_dropped", 64'(bus.cpu_enable), 64'd0);
    chk("t5_busy_dropped", 64'(bus.busy), 64'd0);
    chk("t5_en_cycles", 64'(n_en), 64'd5);
    arst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", 64'(n_done), 64'd0);
    chk("t5_no_read", 64'(rd2_addr.size()), 64'd0);
    run_seq(10'd1, 32'd2, 11'd1, 1'b0, 1'b0, 200);
    chk("t5_restart_write", wr_addr.size() == 1 ? wr_dat[0] : 64'hBAD, 64'(pword(0)));
    chk("t5_restart_en", 64'(n_en), 64'd2);
    chk("t5_restart_out", outq.size() == 1 ? outq[0] : 64'hBAD, dword(0));

    // clamping: prog_len 130 -> 128 words, dump_len 2000 -> 128 words
    run_seq(10'd130, 32'd1, 11'd2000, 1'b0, 1'b0, 2000);
    chk("clamp_nwrites", 64'(wr_addr.size()), 64'd128);
    chk("clamp_last_waddr", wr_addr.size() == 128 ? wr_addr[127] : 64'hBAD, 64'd508);
    chk("clamp_nreads", 64'(rd2_addr.size()), 64'd128);
    chk("clamp_last_raddr", rd2_addr.size() == 128 ? rd2_addr[127] : 64'hBAD, 64'd1016);
    chk("clamp_last_out", outq.size() == 128 ? outq[127] : 64'hBAD, dword(127));

`ifdef LOADER_VERIFY_EN
    // test 6: corrupted readback of word 1 sets error, sequence still completes
    corrupt = 1'b1;
    run_seq(10'd3, 32'd5, 11'd2, 1'b0, 1'b0, 400);
    corrupt = 1'b0;
    chk("t6_error_set", 64'(bus.error), 64'd1);
    chk("t6_reads", 64'(n_ren1), 64'd3);
    chk("t6_run_done", 64'(n_en), 64'd5);
    chk("t6_dump_done", 64'(outq.size()), 64'd2);
    run_seq(10'd3, 32'd1, 11'd0, 1'b0, 1'b0, 400);
    chk("t6_error_cleared", 64'(bus.error), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
